res_st_sched: RTL
=================

Name: res_st_sched

Overview:
- Read-side scheduler for the reservation station. The front end fills the station through its single write port.
- This block scans the station through the four read ports, four entries per cycle. It selects one ready entry, issues it to the execution side over a valid/ready handshake, and then releases the entry.
- It is instantiated inside back_end and driven by schedule_en.

Parameters:
- RES_ST_DEPTH, 16, number of station entries; must be a power of two and at least 4.
- WINDOW, 4, entries examined per scan cycle; fixed at 4, one per read port.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- schedule_en  in  1  enables scanning and issuing.
- flush  in  1  abandons any in-flight selection.
- res_st_rd1_addr..res_st_rd4_addr  out  res_st_addr_t  scan window addresses.
- res_st_rd1_in..res_st_rd4_in  in  res_st_cell_t  entry contents; combinational read, same cycle as the address.
- issue_valid  out  1  issue_uop and issue_addr are valid.
- issue_ready  in  1  execution side accepts the issue.
- issue_uop  out  res_st_cell_t  selected entry.
- issue_addr  out  res_st_addr_t  index of the selected entry.
- release_en  out  1  one-cycle pulse telling res_st to clear the valid bit of release_addr.
- release_addr  out  res_st_addr_t  entry to clear.
- issue_count  out  32  number of completed issue handshakes; wraps.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst). rst has priority over flush, and flush has priority over every other event.
- Reset values: state=IDLE, base=0, issue_valid=0, issue_uop=0, issue_addr=0, release_en=0, release_addr=0, issue_count=0.
- Address outputs: rdK_addr = (base + K-1) mod RES_ST_DEPTH for K=1..4, in every state. Addition is in res_st_addr_t width, so wrap is natural.
- Entry ready condition: ready_K = cell.valid & cell.rs1_rdy & cell.rs2_rdy.
- IDLE state: no outputs asserted. If schedule_en=1, go to SCAN next cycle.
- SCAN state:
  - If schedule_en=0, go to IDLE and keep base.
  - Else if any ready_K is set, take the lowest K (rd1 highest priority). Register its cell into issue_uop and its address into issue_addr, then go to ISSUE. issue_valid=1 from the next cycle.
  - Else set base = base+4 mod depth and stay in SCAN.
- ISSUE state:
  - issue_valid=1, with issue_uop and issue_addr held stable until handshake. schedule_en=0 does not withdraw a pending issue.
  - Handshake occurs on the cycle where issue_valid & issue_ready. On that edge:
    - issue_valid clears;
    - release_addr = issue_addr;
    - release_en=1 on the following cycle;
    - issue_count increments;
    - base = window base + 4 mod depth, for round-robin fairness;
    - go to RELEASE.
  - Minimum issue latency: 1 cycle from entering SCAN with a ready entry to issue_valid.
- RELEASE state:
  - release_en=1 for exactly one cycle; res_st clears the entry on that edge.
  - Go to SCAN if schedule_en=1, else IDLE.
  - This guarantees a released entry is never rescanned before its valid bit clears, so there is no double issue.
- flush:
  - Go to IDLE and clear issue_valid and release_en.
  - No release is issued and issue_count is unchanged; the flushed entry stays valid in res_st.
  - base is kept.
- Front-end write to the entry currently being scanned in the same cycle: the pre-write contents are used, because the read is combinational and res_st writes on the clock edge.
- Back-to-back issues: one issue per 3 cycles at best (SCAN, ISSUE, RELEASE).
- An empty station scans forever with no outputs asserted; base cycles 0,4,8,12,0,...

Decomposition:
- qu_common holds:
  - RES_ST_DEPTH;
  - res_st_addr_t, which is $clog2(RES_ST_DEPTH) bits wide;
  - res_st_cell_t, with fields valid, rs1_rdy and rs2_rdy required by this block;
  - sched_state_t enum {IDLE, SCAN, ISSUE, RELEASE}.
- Sub-module pick4, combinational: takes four ready bits and outputs a found flag and a 2-bit index with rd1 priority.
- res_st gains the release_en and release_addr port in the same change.

Test Plan:
- Ready entry in first window: reset, entries 5 and 9 ready, schedule_en=1, issue_ready=1.
  - Entry 5 issues first (issue_addr=5), release_en pulses with release_addr=5, then entry 9 issues.
  - issue_count=2, with no reissue of 5.
- Priority within a window: entries 2 and 3 both ready -> issue_addr=2 first, then 3 on a later scan.
- Wrap-around: only entry 1 ready, base starting at 12 after an earlier issue from window 8-11.
  - Scan sees window 12-15, then base wraps to 0, and issue_addr=1.
- Backpressure: issue_ready=0 for 10 cycles after issue_valid.
  - issue_valid, issue_uop and issue_addr stay stable, release_en=0, and issue_count is unchanged.
  - With issue_ready=1 on cycle 11: handshake, then release_en=1 on the next cycle.
- Flush during ISSUE: flush=1 while issue_valid=1 -> next cycle issue_valid=0, no release_en, issue_count unchanged, state IDLE.
  - Entry stays valid and reissues once schedule_en=1.
- Reset mid-operation: rst=1 during RELEASE -> next cycle all outputs at reset values and base=0.
  - release_en deasserts the cycle after rst is sampled.

Source files
------------

// File: rtl/res_st_sched_pkg.sv
// Shared types for the reservation-station read-side scheduler.
package res_st_sched_pkg;

    localparam int RES_ST_DEPTH = 16;
    localparam int WINDOW       = 4;
    localparam int ADDR_W       = $clog2(RES_ST_DEPTH);

    typedef logic [ADDR_W-1:0] res_st_addr_t;

    // One station entry; payload carries the rest of the micro-op.
    typedef struct packed {
        logic        valid;
        logic        rs1_rdy;
        logic        rs2_rdy;
        logic [28:0] payload;
    } res_st_cell_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        ISSUE   = 2'd2,
        RELEASE = 2'd3
    } sched_state_t;

    // An entry can issue once it is valid and both sources are ready.
    function automatic logic cell_ready(input res_st_cell_t c);
        return c.valid & c.rs1_rdy & c.rs2_rdy;
    endfunction

endpackage

// File: rtl/res_st_sched_pick4.sv
// Four-way fixed-priority picker; bit 0 (read port 1) wins.
module res_st_sched_pick4 (
    input  logic [3:0] rdy,
    output logic       found,
    output logic [1:0] idx
);

    // Lowest set bit selects the index.
    always_comb begin
        found = |rdy;
        idx   = 2'd0;
        if (rdy[0])      idx = 2'd0;
        else if (rdy[1]) idx = 2'd1;
        else if (rdy[2]) idx = 2'd2;
        else if (rdy[3]) idx = 2'd3;
    end

endmodule

// File: rtl/res_st_sched.sv
// Reservation-station read-side scheduler: scans four entries per cycle,
// issues one ready entry over valid/ready, then pulses a release.
//
// Handshake: issue_valid rises with issue_uop/issue_addr stable and stays
// high until a cycle where issue_valid & issue_ready, which is the transfer;
// only flush or rst may drop issue_valid without a transfer.
module res_st_sched
    import res_st_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         schedule_en,
    input  logic         flush,
    output res_st_addr_t res_st_rd1_addr,
    output res_st_addr_t res_st_rd2_addr,
    output res_st_addr_t res_st_rd3_addr,
    output res_st_addr_t res_st_rd4_addr,
    input  res_st_cell_t res_st_rd1_in,
    input  res_st_cell_t res_st_rd2_in,
    input  res_st_cell_t res_st_rd3_in,
    input  res_st_cell_t res_st_rd4_in,
    output logic         issue_valid,
    input  logic         issue_ready,
    output res_st_cell_t issue_uop,
    output res_st_addr_t issue_addr,
    output logic         release_en,
    output res_st_addr_t release_addr,
    output logic [31:0]  issue_count,
    output logic [1:0]   dbg_state
);

    localparam res_st_addr_t WIN_STEP = res_st_addr_t'(WINDOW);

    sched_state_t state_q, state_d;
    res_st_addr_t base_q, base_d;
    logic         issue_valid_q, issue_valid_d;
    res_st_cell_t issue_uop_q, issue_uop_d;
    res_st_addr_t issue_addr_q, issue_addr_d;
    logic         release_en_q, release_en_d;
    res_st_addr_t release_addr_q, release_addr_d;
    logic [31:0]  issue_count_q, issue_count_d;

    logic [3:0]   win_rdy;
    logic         pick_found;
    logic [1:0]   pick_idx;
    res_st_cell_t pick_cell;

    // Window addresses follow base in every state; wrap is natural.
    assign res_st_rd1_addr = base_q;
    assign res_st_rd2_addr = base_q + res_st_addr_t'(1);
    assign res_st_rd3_addr = base_q + res_st_addr_t'(2);
    assign res_st_rd4_addr = base_q + res_st_addr_t'(3);

    assign win_rdy = {cell_ready(res_st_rd4_in), cell_ready(res_st_rd3_in),
                      cell_ready(res_st_rd2_in), cell_ready(res_st_rd1_in)};

    res_st_sched_pick4 u_pick4 (
        .rdy   (win_rdy),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Route the winning read port's contents toward issue_uop.
    always_comb begin
        pick_cell = res_st_rd1_in;
        case (pick_idx)
            2'd0:    pick_cell = res_st_rd1_in;
            2'd1:    pick_cell = res_st_rd2_in;
            2'd2:    pick_cell = res_st_rd3_in;
            default: pick_cell = res_st_rd4_in;
        endcase
    end

    // Next-state and next-output computation; flush overrides the FSM.
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        issue_valid_d  = issue_valid_q;
        issue_uop_d    = issue_uop_q;
        issue_addr_d   = issue_addr_q;
        release_en_d   = 1'b0;
        release_addr_d = release_addr_q;
        issue_count_d  = issue_count_q;

        case (state_q)
            IDLE: begin
                if (schedule_en) state_d = SCAN;
            end
            SCAN: begin
                if (!schedule_en) begin
                    state_d = IDLE;
                end else if (pick_found) begin
                    issue_uop_d   = pick_cell;
                    issue_addr_d  = base_q + res_st_addr_t'(pick_idx);
                    issue_valid_d = 1'b1;
                    state_d       = ISSUE;
                end else begin
                    base_d = base_q + WIN_STEP;
                end
            end
            ISSUE: begin
                // base still holds the window the entry came from.
                if (issue_valid_q && issue_ready) begin
                    issue_valid_d  = 1'b0;
                    release_addr_d = issue_addr_q;
                    release_en_d   = 1'b1;
                    issue_count_d  = issue_count_q + 32'd1;
                    base_d         = base_q + WIN_STEP;
                    state_d        = RELEASE;
                end
            end
            RELEASE: begin
                state_d = schedule_en ? SCAN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d        = IDLE;
            base_d         = base_q;
            issue_valid_d  = 1'b0;
            issue_uop_d    = issue_uop_q;
            issue_addr_d   = issue_addr_q;
            release_en_d   = 1'b0;
            release_addr_d = release_addr_q;
            issue_count_d  = issue_count_q;
        end
    end

    // State and registered outputs, synchronous reset first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            base_q         <= '0;
            issue_valid_q  <= 1'b0;
            issue_uop_q    <= '0;
            issue_addr_q   <= '0;
            release_en_q   <= 1'b0;
            release_addr_q <= '0;
            issue_count_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            issue_valid_q  <= issue_valid_d;
            issue_uop_q    <= issue_uop_d;
            issue_addr_q   <= issue_addr_d;
            release_en_q   <= release_en_d;
            release_addr_q <= release_addr_d;
            issue_count_q  <= issue_count_d;
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_uop    = issue_uop_q;
    assign issue_addr   = issue_addr_q;
    assign release_en   = release_en_q;
    assign release_addr = release_addr_q;
    assign issue_count  = issue_count_q;
    assign dbg_state    = state_q;

endmodule
